flux_rr_arbiter: RTL



---
 rtl/flux_rr_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/flux_rr_arbiter.sv
// Burst-limited round-robin tag arbiter for multi-flux tagged actors.
// Optional per-flux fire counters are built when ARB_STATS_EN is defined.
module flux_rr_arbiter #(
  parameter int FLUX = 2,
  parameter int MAX_BURST = 4,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int BCNT_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLUX-1:0]      req,
  input  logic                 fire,
  output logic                 grant_valid,
  output logic [TAG_WIDTH-1:0] grant_tag,
  output logic [FLUX-1:0]      grant_onehot,
  output logic                 rotate,
  input  logic [TAG_WIDTH-1:0] stat_sel,
  input  logic                 stat_clr,
  output logic [15:0]          stat_cnt
);

  logic [TAG_WIDTH-1:0]  ptr;
  logic [TAG_WIDTH-1:0]  last_tag;
  logic                  last_valid;
  logic [BCNT_WIDTH-1:0] burst_cnt;
  logic [BCNT_WIDTH-1:0] n_cnt;
  logic [TAG_WIDTH-1:0]  next_ptr;
  logic                  eff_fire;
  logic                  force_rot;

  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_tag   = '0;
    for (int k = 0; k < FLUX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= FLUX) idx = idx - FLUX;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_tag   = TAG_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < FLUX; i++) begin
      grant_onehot[i] = grant_valid && (grant_tag == TAG_WIDTH'(i));
    end
  end

  assign eff_fire = fire && grant_valid;

  always_comb begin
    if (last_valid && (grant_tag == last_tag)) begin
      n_cnt = burst_cnt + BCNT_WIDTH'(1);
    end else begin
      n_cnt = BCNT_WIDTH'(1);
    end
  end

  assign force_rot = (n_cnt >= BCNT_WIDTH'(MAX_BURST));

  // Wrap explicitly: FLUX need not be a power of two.
  assign next_ptr = (grant_tag == TAG_WIDTH'(FLUX - 1))
                  ? '0 : grant_tag + TAG_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      burst_cnt  <= '0;
      last_tag   <= '0;
      last_valid <= 1'b0;
      rotate     <= 1'b0;
    end else begin
      rotate <= 1'b0;
      if (eff_fire) begin
        if (force_rot) begin
          ptr        <= next_ptr;
          burst_cnt  <= '0;
          last_valid <= 1'b0;
          rotate     <= 1'b1;
        end else begin
          ptr        <= grant_tag;
          burst_cnt  <= n_cnt;
          last_tag   <= grant_tag;
          last_valid <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt_q [FLUX];

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < FLUX; i++) cnt_q[i] <= '0;
    end else if (eff_fire) begin
      for (int i = 0; i < FLUX; i++) begin
        if (grant_tag == TAG_WIDTH'(i) && cnt_q[i] != 16'hFFFF) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (stat_sel == TAG_WIDTH'(i)) stat_cnt = cnt_q[i];
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_cnt    = '0;
`endif

endmodule
